// File: rtl/clk_div_prog_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
package clk_div_prog_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    // Period/high-time pair at the default counter width.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] high;
    } div_cfg_t;

    // ST_START: the next enabled edge enters phase 0. ST_RUN: counting.
    typedef enum logic {
        ST_START = 1'b0,
        ST_RUN   = 1'b1
    } ch_state_e;

    function automatic int unsigned def_high(input int unsigned def_div);
        return def_div / 2;
    endfunction

    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Configuration and output bundle between a controller and clk_div_prog.
interface clk_div_prog_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
);
    import clk_div_prog_pkg::*;

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic              cfg_we_i;
    logic [CH_W-1:0]   cfg_ch_i;
    logic [CNT_W-1:0]  cfg_div_i;
    logic [CNT_W-1:0]  cfg_high_i;
    logic [NUM_CH-1:0] en_i;
    logic              sync_i;
    logic [NUM_CH-1:0] clk_o;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] cfg_pend_o;

    modport master (
        output cfg_we_i, cfg_ch_i, cfg_div_i, cfg_high_i, en_i, sync_i,
        input  clk_o, tick_o, cfg_pend_o
    );

    modport slave (
        input  cfg_we_i, cfg_ch_i, cfg_div_i, cfg_high_i, en_i, sync_i,
        output clk_o, tick_o, cfg_pend_o
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active period registers, phase counter and
// registered divided-clock and tick outputs.
module clk_div_ch #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 25000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             en,
    input  logic             sync,
    output logic             div_clk,
    output logic             tick,
    output logic             pend
);
    import clk_div_prog_pkg::*;

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(def_high(DEF_DIV));

    ch_state_e        state_q, state_d;
    cfg_t             act_q, act_d, sh_q, sh_d, eff;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             wrap, enter0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            act_q   <= '{div: RST_DIV, high: RST_HIGH};
            sh_q    <= '{div: RST_DIV, high: RST_HIGH};
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        sh_d    = sh_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
        cnt_inc = cnt_q + CNT_W'(1);
        wrap    = (cnt_q == act_q.div - CNT_W'(1));
        enter0  = sync || (state_q == ST_START) || wrap;
        // Phase-0 entry uses the pre-write shadow, so a write on this edge
        // waits for the next phase-0 entry.
        eff     = pend_q ? sh_q : act_q;

        if (!en) begin
            state_d = ST_START;
            cnt_d   = '0;
        end else if (enter0) begin
            act_d  = eff;
            pend_d = 1'b0;
            cnt_d  = '0;
            if (eff.div == '0) begin
                state_d = ST_START;
            end else begin
                state_d = ST_RUN;
                tick_d  = 1'b1;
                clk_d   = (eff.high != '0);
            end
        end else begin
            state_d = ST_RUN;
            cnt_d   = cnt_inc;
            clk_d   = (cnt_inc < act_q.high);
        end

        if (we) begin
            sh_d   = '{div: cfg_div, high: cfg_high};
            pend_d = 1'b1;
        end
    end

    assign div_clk = clk_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider and tick generator.
module clk_div_prog #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 25000
) (
    input logic           clk_i,
    input logic           rst_ni,
    clk_div_prog_if.slave bus
);
    import clk_div_prog_pkg::*;

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    // Indices at or beyond NUM_CH match no channel, so those writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = bus.cfg_we_i && (bus.cfg_ch_i == CH_W'(i));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .we       (sel),
            .cfg_div  (bus.cfg_div_i),
            .cfg_high (bus.cfg_high_i),
            .en       (bus.en_i[i]),
            .sync     (bus.sync_i),
            .div_clk  (bus.clk_o[i]),
            .tick     (bus.tick_o[i]),
            .pend     (bus.cfg_pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random traffic
// checked cycle by cycle against a phase-position reference model.
module tb_clk_div_prog;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DEF_DIV = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_prog #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    // Reference model: each channel is a position inside its period.
    int unsigned a_div[NUM_CH], a_high[NUM_CH], s_div[NUM_CH], s_high[NUM_CH], pos[NUM_CH];
    bit running[NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                a_div[c] = DEF_DIV; a_high[c] = DEF_DIV / 2;
                s_div[c] = DEF_DIV; s_high[c] = DEF_DIV / 2;
                pos[c] = 0; running[c] = 0;
            end
            e_clk = '0; e_tick = '0; e_pend = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                bit phase0;
                if (!bus.en_i[c]) begin
                    running[c] = 0; pos[c] = 0; e_clk[c] = 0; e_tick[c] = 0;
                end else begin
                    phase0 = bus.sync_i || !running[c] || ((pos[c] + 1) % a_div[c] == 0);
                    if (phase0 && e_pend[c]) begin
                        a_div[c] = s_div[c]; a_high[c] = s_high[c];
                    end
                    if (phase0) begin
                        e_pend[c] = 0; pos[c] = 0;
                    end else begin
                        pos[c] = pos[c] + 1;
                    end
                    running[c] = (a_div[c] != 0);
                    if (!running[c]) pos[c] = 0;
                    e_tick[c] = running[c] && (pos[c] == 0);
                    e_clk[c]  = running[c] && (pos[c] < a_high[c]);
                end
                if (bus.cfg_we_i && bus.cfg_ch_i == c) begin
                    s_div[c] = bus.cfg_div_i; s_high[c] = bus.cfg_high_i; e_pend[c] = 1;
                end
            end
        end
    end

    task automatic cfg_write(input int unsigned ch, input int unsigned dv, input int unsigned hi);
        bus.cfg_we_i = 1'b1; bus.cfg_ch_i = 2'(ch);
        bus.cfg_div_i = CNT_W'(dv); bus.cfg_high_i = CNT_W'(hi);
        @(negedge clk);
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.en_i = '0; bus.sync_i = 1'b0; bus.cfg_we_i = 1'b0;
        bus.cfg_ch_i = '0; bus.cfg_div_i = '0; bus.cfg_high_i = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== 12'h000)
            $display("FAIL reset_outputs got %b exp 0", {bus.clk_o, bus.tick_o, bus.cfg_pend_o});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== 12'h000)
                $display("FAIL disabled_idle got %b exp 0", {bus.clk_o, bus.tick_o, bus.cfg_pend_o});
            else pass_cnt++;
        end
    endtask

    task automatic test_defaults();
        int unsigned highs0 = 0, ticks0 = 0;
        bus.en_i = '1;
        for (int unsigned k = 0; k < 40; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL defaults_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (k == 0) begin
                total_cnt++;
                if (bus.tick_o !== 4'hF) $display("FAIL first_tick got %b exp 1111", bus.tick_o);
                else pass_cnt++;
            end
            if (k < 10 && bus.clk_o[0]) highs0++;
            if (bus.tick_o[0]) ticks0++;
        end
        total_cnt++;
        if (highs0 != 5) $display("FAIL default_high_time got %0d exp 5", highs0); else pass_cnt++;
        total_cnt++;
        if (ticks0 != 4) $display("FAIL default_tick_count got %0d exp 4", ticks0); else pass_cnt++;
    endtask

    task automatic test_reprogram();
        int unsigned n = 0, pend_cycles = 0, highs = 0, ticks = 0;
        while (pos[1] != 3 && n < 30) begin @(negedge clk); n++; end
        if (n >= 30) begin total_cnt++; $display("FAIL reprog_align got timeout exp cnt=3"); end
        bus.cfg_we_i = 1'b1; bus.cfg_ch_i = 2'd1; bus.cfg_div_i = 8'd4; bus.cfg_high_i = 8'd1;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.cfg_we_i = 1'b0;
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL reprog_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (!bus.cfg_pend_o[1]) break;
            pend_cycles++;
        end
        total_cnt++;
        if (pend_cycles != 6) $display("FAIL reprog_pend_len got %0d exp 6", pend_cycles); else pass_cnt++;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL reprog_model2 t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (bus.clk_o[1]) highs++;
            if (bus.tick_o[1]) ticks++;
        end
        total_cnt++;
        if (highs != 2) $display("FAIL reprog_high got %0d exp 2", highs); else pass_cnt++;
        total_cnt++;
        if (ticks != 2) $display("FAIL reprog_ticks got %0d exp 2", ticks); else pass_cnt++;
    endtask

    task automatic test_edge_values();
        bit tick0_all = 1, ch1_quiet = 1, clk2_all = 1, clk3_none = 1;
        int unsigned ticks3 = 0;
        cfg_write(0, 1, 1); cfg_write(1, 0, 3); cfg_write(2, 8, 12); cfg_write(3, 8, 0);
        for (int unsigned k = 0; k < 41; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL edge_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (k >= 25) begin
                tick0_all &= bus.tick_o[0];
                ch1_quiet &= !bus.clk_o[1] && !bus.tick_o[1];
                clk2_all  &= bus.clk_o[2];
                clk3_none &= !bus.clk_o[3];
                if (bus.tick_o[3]) ticks3++;
            end
        end
        total_cnt++;
        if (!tick0_all) $display("FAIL div1_tick got 0 exp constant 1"); else pass_cnt++;
        total_cnt++;
        if (!ch1_quiet) $display("FAIL div0_off got activity exp 0"); else pass_cnt++;
        total_cnt++;
        if (!clk2_all) $display("FAIL high_ge_div got 0 exp constant 1"); else pass_cnt++;
        total_cnt++;
        if (!clk3_none) $display("FAIL high0_clk got 1 exp constant 0"); else pass_cnt++;
        total_cnt++;
        if (ticks3 != 2) $display("FAIL high0_ticks got %0d exp 2", ticks3); else pass_cnt++;
    endtask

    task automatic test_wrap_write();
        int unsigned n = 0, gap = 0;
        while (pos[3] != 7 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin total_cnt++; $display("FAIL wrap_align got timeout exp pos=7"); end
        bus.cfg_we_i = 1'b1; bus.cfg_ch_i = 2'd3; bus.cfg_div_i = 8'd5; bus.cfg_high_i = 8'd2;
        @(negedge clk);
        bus.cfg_we_i = 1'b0;
        total_cnt++;
        if ({bus.tick_o[3], bus.cfg_pend_o[3]} !== 2'b11)
            $display("FAIL wrap_write_pend got %b exp 11", {bus.tick_o[3], bus.cfg_pend_o[3]});
        else pass_cnt++;
        for (int unsigned k = 1; k <= 20; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL wrap_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (bus.tick_o[3]) begin gap = k; break; end
        end
        total_cnt++;
        if (gap != 8) $display("FAIL wrap_old_period got %0d exp 8", gap); else pass_cnt++;
        cfg_write(3, 6, 3); cfg_write(3, 3, 1);
        n = 0;
        while (!bus.tick_o[3] && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin total_cnt++; $display("FAIL double_write_align got timeout exp tick"); end
        gap = 0;
        for (int unsigned k = 1; k <= 20; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL double_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (bus.tick_o[3]) begin gap = k; break; end
        end
        total_cnt++;
        if (gap != 3) $display("FAIL double_write_period got %0d exp 3", gap); else pass_cnt++;
    endtask

    task automatic test_sync_enable();
        cfg_write(0, 5, 2); cfg_write(1, 7, 3); cfg_write(2, 9, 4); cfg_write(3, 4, 1);
        repeat (25 + $urandom_range(0, 6)) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL sync_pre_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
        end
        bus.sync_i = 1'b1;
        @(negedge clk);
        bus.sync_i = 1'b0;
        total_cnt++;
        if (bus.tick_o !== 4'hF) $display("FAIL sync_ticks got %b exp 1111", bus.tick_o); else pass_cnt++;
        repeat (5) @(negedge clk);
        bus.en_i = 4'b1011;
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o[2], bus.tick_o[2]} !== 2'b00)
                $display("FAIL disable_outputs got %b exp 00", {bus.clk_o[2], bus.tick_o[2]});
            else pass_cnt++;
        end
        bus.en_i = 4'hF;
        @(negedge clk);
        total_cnt++;
        if ({bus.tick_o[2], bus.clk_o[2]} !== 2'b11)
            $display("FAIL reenable_phase0 got %b exp 11", {bus.tick_o[2], bus.clk_o[2]});
        else pass_cnt++;
        repeat (10) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL sync_post_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int unsigned idx;
        for (int unsigned k = 0; k < 1500; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL random_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            bus.cfg_we_i   = ($urandom_range(0, 3) == 0);
            bus.cfg_ch_i   = 2'($urandom_range(0, 3));
            bus.cfg_div_i  = CNT_W'($urandom_range(0, 12));
            bus.cfg_high_i = CNT_W'($urandom_range(0, 14));
            bus.sync_i     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) begin
                idx = $urandom_range(0, NUM_CH - 1);
                bus.en_i[idx] = ~bus.en_i[idx];
            end
        end
        bus.cfg_we_i = 1'b0; bus.sync_i = 1'b0; bus.en_i = '1;
    endtask

    task automatic test_async_reset();
        int unsigned n = 0, highs = 0;
        cfg_write(0, 12, 11);
        repeat (30) @(negedge clk);
        while (!(e_clk[0] && pos[0] < 8) && n < 30) begin @(negedge clk); n++; end
        if (n >= 30) begin total_cnt++; $display("FAIL arst_align got timeout exp high phase"); end
        bus.cfg_we_i = 1'b1; bus.cfg_ch_i = 2'd1; bus.cfg_div_i = 8'd9; bus.cfg_high_i = 8'd4;
        @(posedge clk);
        #2;
        bus.cfg_we_i = 1'b0;
        total_cnt++;
        if ({bus.clk_o[0], bus.cfg_pend_o[1]} !== 2'b11)
            $display("FAIL arst_pre got %b exp 11", {bus.clk_o[0], bus.cfg_pend_o[1]});
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== 12'h000)
            $display("FAIL arst_async got %b exp 0", {bus.clk_o, bus.tick_o, bus.cfg_pend_o});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 25; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.clk_o, bus.tick_o, bus.cfg_pend_o} !== {e_clk, e_tick, e_pend})
                $display("FAIL arst_model t=%0t got %b exp %b", $time, {bus.clk_o, bus.tick_o, bus.cfg_pend_o}, {e_clk, e_tick, e_pend});
            else pass_cnt++;
            if (k == 0) begin
                total_cnt++;
                if ({bus.tick_o, bus.clk_o} !== 8'hFF) $display("FAIL arst_restart got %b exp ff", {bus.tick_o, bus.clk_o});
                else pass_cnt++;
            end
            if (k < 10 && bus.clk_o[1]) highs++;
        end
        total_cnt++;
        if (highs != 5) $display("FAIL arst_default_high got %0d exp 5", highs); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reprogram();
        test_edge_values();
        test_wrap_write();
        test_sync_enable();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel, runtime-programmable clock divider and tick generator; the parametrised successor to the fixed single-output divider. Each of `NUM_CH` channels produces a divided square wave with programmable period and high time, plus a one-cycle `tick_o` strobe at each period start. Divisor changes are glitch-free. Channels can be enabled individually and phase-aligned together. It sits next to the system clock and drives scan, debounce and baud-rate timing for the peripheral blocks.

## Interface
- `NUM_CH`, default 4: number of independent channels (1..16).
- `CNT_W`, default 16: width of the divisor, high-time and counter registers.
- `DEF_DIV`, default 25000: reset period of every channel, in `clk_i` cycles. Must satisfy 1 ≤ `DEF_DIV` < 2^`CNT_W`.
- `clk_i`, in, 1: system clock; all logic is on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `cfg_we_i`, in, 1: configuration write strobe.
- `cfg_ch_i`, in, max(1,$clog2(NUM_CH)): target channel. A write to an index ≥ `NUM_CH` is ignored.
- `cfg_div_i`, in, `CNT_W`: new period, in cycles.
- `cfg_high_i`, in, `CNT_W`: new high time, in cycles.
- `en_i`, in, `NUM_CH`: per-channel run enable.
- `sync_i`, in, 1: restart every enabled channel at phase 0.
- `clk_o`, out, `NUM_CH`: divided clocks, registered.
- `tick_o`, out, `NUM_CH`: one-cycle period-start strobes, registered.
- `cfg_pend_o`, out, `NUM_CH`: a shadow configuration is waiting to be applied.

## Operation
- **Per-channel state:** active {div, high}, shadow {div, high}, `pend`, counter `cnt`, and a `start` flag.
- **Reset values:** active and shadow div = `DEF_DIV`, high = `DEF_DIV`/2. `cnt` = 0, `start` = 1, `pend` = 0. All `clk_o`, `tick_o` and `cfg_pend_o` are 0.
- **Configuration write:** a write at edge E loads the shadow registers and sets `pend`. A second write before the shadow is applied overwrites it; only the last value is used.
- **Shadow apply:** the shadow is copied to active when the channel enters phase 0, i.e. on a wrap, a start or a sync. `pend` clears on the same edge.
  - A write at edge E is applied at the first phase-0 entry strictly after E. A write coincident with a wrap waits for the next wrap.
- **Disabled channel (`en_i` = 0):** `cnt` ← 0, `start` ← 1, `clk_o` ← 0, `tick_o` ← 0. Shadow writes are still accepted.
- **Start edge (enabled and `start` = 1, or `sync_i` = 1):**
  - `cnt` ← 0, `start` ← 0, `tick_o` ← 1.
  - `clk_o` ← (0 < high), using the post-apply values.
- **Run edge:** `cnt_n` = (`cnt` = div−1) ? 0 : `cnt`+1.
  - `tick_o` ← (`cnt_n` = 0).
  - `clk_o` ← (`cnt_n` < high).
  - On wrap, the shadow applies before the `clk_o` comparison.
- **Boundary values:**
  - div = 0: channel is off. Outputs are held at 0, `cnt` is held at 0, and `start` stays 1.
  - div = 1: `tick_o` is constant 1, and `clk_o` = (high ≥ 1).
  - high ≥ div: `clk_o` is constant 1.
  - high = 0: `clk_o` is constant 0, but ticks still fire.
- **Priority:** reset > `en_i` = 0 > `sync_i` > start > run.
- **Widths:** all comparisons are unsigned and `CNT_W` bits wide. No arithmetic overflows, because `cnt` ≤ div−1.

## Timing
- **Output latency:** one cycle from the sampled inputs. The cycle after `en_i` is first seen high shows phase 0 (`tick_o` = 1).
- **Period and duty:** period = div cycles and high time = min(high, div) cycles, both exact. There is no drift across reconfiguration.
- **Ticks:** `tick_o` pulses are exactly one cycle wide. When div ≥ 2, consecutive pulses are div cycles apart.
- **`sync_i`:** aligns all enabled channels on the same edge.
- **Reset mid-period:** all outputs drop to 0 immediately, asynchronously. Reset release is synchronised externally.
- **Glitch-free:** `clk_o` never produces a pulse shorter than min(high, div−high) of either the old or the new configuration.

## Structure
- **Package `clk_div_prog_pkg`:**
  - typedef `div_cfg_t` = struct {div, high}, both `CNT_W` bits wide.
  - `DEF_HIGH` = `DEF_DIV`/2 (function).
  - Channel-index width helper.
- **Sub-module `clk_div_ch`:** one channel holding its counter, shadow/active registers and output flops. Top level `clk_div_prog` instantiates it `NUM_CH` times with a generate loop and does the `cfg_ch_i` decode.

## Test plan
- **Reset defaults:** `DEF_DIV` = 10, all `en_i` = 1 after reset → each `clk_o` is 5 cycles high, 5 cycles low; `tick_o` pulses every 10 cycles; the first tick comes 1 cycle after `en_i` is seen high.
- **Reprogram mid-period:** channel 1, write div = 4, high = 1 at `cnt` = 3 of a 10-cycle period → the old period completes (6 more cycles), then the output is 1 cycle high, 3 cycles low. `cfg_pend_o[1]` is high until the wrap edge.
- **Edge values:** div = 1 → `tick_o` constant 1. div = 0 → `clk_o` = `tick_o` = 0. high = 12 with div = 8 → `clk_o` constant 1. high = 0 → `clk_o` 0 with ticks every 8 cycles.
- **Write coincident with wrap, then double write:** write on the wrap edge applies one period later. Two writes (div 6, then div 3) before the wrap → only div 3 is used.
- **`sync_i` and enable:** `sync_i` with channels at different phases → all `tick_o` pulses coincide on the next cycle. Toggling `en_i[2]` low for 3 cycles → outputs are 0, and restart is at phase 0.
- **Asynchronous reset:** assert `rst_ni` mid-high-phase with pending writes → outputs clear without a clock edge, `cfg_pend_o` = 0, and defaults are restored.
